// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: alignment check, lane/byte-enable
// generation, single outstanding request with ack wait-timeout, load extension.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] ResM,
    input  logic [31:0] WDMemoryM,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata_out,
    output logic        addr_err,
    output logic        bus_err
);

    localparam int unsigned CNT_W     = 8;
    localparam int unsigned DATA_W    = 32;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(254);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_we;
    logic [3:0]          r_be;
    logic [DATA_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [1:0]          r_size;
    logic [1:0]          r_lane;
    logic                r_uns;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_addr_err;
    logic                r_bus_err;

    logic                w_req;
    logic                w_misalign;
    logic                w_idle_like;
    logic                w_accept;
    logic                w_timeout;
    logic [3:0]          w_be;
    logic [DATA_W-1:0]   w_wdata;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [DATA_W-1:0]   w_load;

    // A request with neither load nor store set carries no memory op.
    assign w_req       = req_valid & (MemWriteM | MemReadM);
    assign w_misalign  = ((size == 2'b01) & ResM[0]) | (size[1] & (|ResM[1:0]));
    assign w_idle_like = (r_state != BUSY);
    assign w_accept    = w_idle_like & w_req & ~w_misalign;

    assign stall     = w_accept | (r_state == BUSY);
    assign dm_req    = (r_state == BUSY);
    assign done      = (r_state == DONE);
    assign dm_we     = r_we;
    assign dm_be     = r_be;
    assign dm_addr   = r_addr;
    assign dm_wdata  = r_wdata;
    assign rdata_out = r_rdata;
    assign addr_err  = r_addr_err;
    assign bus_err   = r_bus_err;

    // Byte enables and replicated store data for the incoming request.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = WDMemoryM;
        case (size)
            2'b00: begin
                w_be    = 4'b0001 << ResM[1:0];
                w_wdata = {4{WDMemoryM[7:0]}};
            end
            2'b01: begin
                w_be    = ResM[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{WDMemoryM[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane select and extension of returned load data.
    always_comb begin
        w_byte = dm_rdata[7:0];
        case (r_lane)
            2'd1:    w_byte = dm_rdata[15:8];
            2'd2:    w_byte = dm_rdata[23:16];
            2'd3:    w_byte = dm_rdata[31:24];
            default: ;
        endcase
        w_half = r_lane[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        w_load = dm_rdata;
        case (r_size)
            2'b00:   w_load = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: ;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            IDLE, DONE: w_next = w_accept ? BUSY : IDLE;
            BUSY: begin
                if (dm_ack) begin
                    w_next = DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_next    = DONE;
                    w_timeout = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_be       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= '0;
            r_lane     <= '0;
            r_uns      <= 1'b0;
            r_rdata    <= '0;
            r_addr_err <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_addr_err <= w_idle_like & w_req & w_misalign;
            r_bus_err  <= w_timeout;
            if (w_accept) begin
                r_cnt   <= '0;
                r_we    <= MemWriteM;
                r_be    <= w_be;
                r_addr  <= {ResM[31:2], 2'b00};
                r_wdata <= w_wdata;
                r_size  <= size;
                r_lane  <= ResM[1:0];
                r_uns   <= load_unsigned;
            end else if ((r_state == BUSY) && !dm_ack) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if ((r_state == BUSY) && dm_ack && !r_we) begin
                r_rdata <= w_load;
            end else if (w_timeout) begin
                r_rdata <= '0;
            end
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-002 The block SHALL have port: reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-003 The block SHALL have port: req_valid  in  1  MEM-stage instruction carries a memory op.
REQ-004 The block SHALL have port: MemWriteM  in  1  store.
REQ-005 The block SHALL have port: MemReadM  in  1  load.
REQ-006 The block SHALL have port: size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-007 The block SHALL have port: load_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
REQ-008 The block SHALL have port: ResM  in  32  byte address from the EX/MEM register.
REQ-009 The block SHALL have port: WDMemoryM  in  32  store data from the EX/MEM register.
REQ-010 The block SHALL have ports to data memory: dm_req out 1, dm_we out 1, dm_be out 4, dm_addr out 32, dm_wdata out 32, dm_ack in 1, dm_rdata in 32.
REQ-011 The block SHALL have pipeline-side ports: stall out 1, done out 1, rdata_out out 32, addr_err out 1, bus_err out 1.

Function
REQ-012 FSM states SHALL be IDLE, BUSY, DONE; DONE SHALL accept a new request exactly as IDLE does.
REQ-013 Misalignment SHALL be: half with ResM[0]=1, word with ResM[1:0]!=00; byte never misaligned.
REQ-014 In IDLE/DONE with req_valid=1 and aligned, the block SHALL latch op, size, load_unsigned, address, data and go to BUSY next edge.
REQ-015 In IDLE/DONE with req_valid=1 and misaligned, the block SHALL issue no memory access, pulse addr_err for one cycle on the next edge and stay in IDLE.
REQ-016 stall SHALL be combinational: 1 when (IDLE or DONE) and req_valid and aligned, or when in BUSY; else 0.
REQ-017 In BUSY, dm_req SHALL be 1 and dm_we, dm_be, dm_addr, dm_wdata SHALL be stable from latched values until the cycle dm_ack=1.
REQ-018 dm_addr SHALL be {addr[31:2],2'b00}; dm_we SHALL be 1 for stores, 0 for loads; if both MemWriteM and MemReadM are 1, store SHALL win.
REQ-019 dm_be SHALL be byte: 4'b0001<<addr[1:0]; half: addr[1]?1100:0011; word: 1111.
REQ-020 dm_wdata SHALL replicate the low byte x4 for byte stores, the low half x2 for half stores, and pass word stores unchanged.
REQ-021 On dm_ack in BUSY, the block SHALL go to DONE; for loads it SHALL register rdata_out = selected lane of dm_rdata, sign- or zero-extended per load_unsigned; for stores rdata_out SHALL hold.
REQ-022 done SHALL be 1 for exactly the one cycle in DONE.
REQ-023 Minimum latency SHALL be: request seen at edge 0, dm_req high cycle 1, ack in cycle 1, done in cycle 2.
REQ-024 An 8-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack; at count 255 the block SHALL drop dm_req, go to DONE, pulse bus_err with done, and set rdata_out=0.
REQ-025 dm_ack outside BUSY SHALL be ignored.

Reset
REQ-026 reset=0 SHALL immediately force state IDLE and set dm_req, dm_we, stall-register terms, done, addr_err, bus_err, dm_be, dm_addr, dm_wdata, rdata_out and wait counter to 0, including mid-transaction.
REQ-027 After reset release, no dm_req SHALL assert until a new aligned req_valid is seen.

Verification
REQ-028 Word load at 0x0000_0010, dm_ack in first BUSY cycle, dm_rdata=0x8000_00FF -> dm_be=1111, done 2 cycles after request, rdata_out=0x8000_00FF.
REQ-029 Signed byte load at 0x...03, dm_rdata=0x80_12_34_56 -> dm_be=1000, rdata_out=0xFFFF_FF80; with load_unsigned=1 -> 0x0000_0080.
REQ-030 Half store 0x1234_ABCD at 0x...02 with dm_ack after 3 wait cycles -> dm_be=1100, dm_wdata=0xABCD_ABCD, stall high 4 cycles, done one cycle.
REQ-031 Word load at 0x...01 -> no dm_req, stall 0, addr_err pulse one cycle.
REQ-032 Load with dm_ack never asserted -> dm_req drops after 255 BUSY cycles, done and bus_err pulse together, rdata_out=0.
REQ-033 reset=0 asserted in BUSY -> dm_req and stall go 0 without waiting for clk; late dm_ack after release is ignored.
